// File: rtl/fifo_uart_tx.sv
// Purpose: pops bytes from an 8x8 FIFO and sends each one as an 8N1 serial frame on tx.
// Latency: first start bit 2 cycles after the read strobe; frame is 10*CLKS_PER_BIT cycles long.
// Backpressure: one read outstanding at most; an empty FIFO (error=1) causes POLL_GAP idle cycles.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int POLL_GAP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_error,
  output logic       fifo_ren,
  output logic       tx,
  output logic       busy,
  output logic [7:0] sent_cnt
);

  localparam int MAXC = (CLKS_PER_BIT > POLL_GAP) ? CLKS_PER_BIT : POLL_GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_BACKOFF = 3'd3;
  localparam logic [2:0] S_START   = 3'd4;
  localparam logic [2:0] S_DATA    = 3'd5;
  localparam logic [2:0] S_STOP    = 3'd6;

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(POLL_GAP - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    sent_cnt_q, sent_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ren_q, ren_d;

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    sent_cnt_d = sent_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        cyc_d = '0;
        if (fifo_error) begin
          state_d = S_BACKOFF;
        end else begin
          shift_d = fifo_dout;
          state_d = S_START;
        end
      end
      S_BACKOFF: begin
        if (cyc_q == GAP_LAST) begin
          cyc_d   = '0;
          state_d = en ? S_REQ : S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_START: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d      = '0;
          sent_cnt_d = sent_cnt_q + 8'd1;
          state_d    = en ? S_REQ : S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase

    ren_d  = (state_d == S_REQ);
    busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
    else                        tx_d = 1'b1;
  end

  // State and output registers; reset abandons any frame in flight and returns the line high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      sent_cnt_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ren_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      sent_cnt_q <= sent_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ren_q      <= ren_d;
    end
  end

  assign fifo_ren = ren_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign sent_cnt = sent_cnt_q;

endmodule
